// File: rtl/divisor_nb.sv
// divisor_nb: button-driven numerator/denominator entry, restoring
// division (one quotient bit per clock) and paged result display.
// Optional feature macro: DIVISOR_ZERO_GUARD_EN -- when defined, ok with a
// zero denominator is refused (state stays in ENTER_DEN, err is raised).
module divisor_nb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             ok,
    output logic [WIDTH-1:0] leds,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        ENTER_NUM = 3'd0,
        ENTER_DEN = 3'd1,
        DIVIDE    = 3'd2,
        SHOW_NUM  = 3'd3,
        SHOW_DEN  = 3'd4,
        SHOW_QUO  = 3'd5,
        SHOW_REM  = 3'd6
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    // quo_q doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             start_div;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Modulo-2^WIDTH edit of an entered value; simultaneous up/down cancel.
    function automatic logic [WIDTH-1:0] edit_value(input logic [WIDTH-1:0] v,
                                                    input logic inc,
                                                    input logic dec);
        if (inc && !dec) return v + WIDTH'(1);
        if (dec && !inc) return v - WIDTH'(1);
        return v;
    endfunction

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ENTER_NUM;
            num_q   <= '0;
            den_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic, value entry and one restoring-division step per cycle.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        den_d     = den_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        start_div = 1'b0;
        // Remainder is always below den, so the top bit of shifted never
        // makes a valid trial result look negative.
        shifted   = {rem_q, quo_q[WIDTH-1]};
        trial     = shifted - {2'b00, den_q};
        case (state_q)
            ENTER_NUM: begin
                if (ok) state_d = ENTER_DEN;
                else    num_d   = edit_value(num_q, up, down);
            end
            ENTER_DEN: begin
                if (ok) begin
`ifdef DIVISOR_ZERO_GUARD_EN
                    if (den_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        start_div = 1'b1;
                        err_d     = 1'b0;
                    end
`else
                    start_div = 1'b1;
                    err_d     = (den_q == '0);
`endif
                end else begin
                    den_d = edit_value(den_q, up, down);
                end
            end
            DIVIDE: begin
                if (trial[WIDTH+1]) begin
                    rem_d = shifted[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = SHOW_QUO;
                    done_d  = 1'b1;
                end
            end
            SHOW_NUM: if (ok) state_d = SHOW_DEN;
            SHOW_DEN: if (ok) state_d = SHOW_QUO;
            SHOW_QUO: if (ok) state_d = SHOW_REM;
            SHOW_REM: begin
                if (ok) begin
                    state_d = ENTER_NUM;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ENTER_NUM;
        endcase
        if (start_div) begin
            state_d = DIVIDE;
            rem_d   = '0;
            quo_d   = num_q;
            cnt_d   = '0;
        end
    end

    // Output decode: LED page select and status flags.
    always_comb begin
        leds = '0;
        case (state_q)
            ENTER_NUM, SHOW_NUM: leds = num_q;
            ENTER_DEN, SHOW_DEN: leds = den_q;
            SHOW_QUO:            leds = quo_q;
            SHOW_REM:            leds = rem_q[WIDTH-1:0];
            default:             leds = '0;
        endcase
        phase = state_q;
        busy  = (state_q == DIVIDE);
        done  = done_q;
        err   = err_q;
    end

endmodule

// File: tb/tb_divisor_nb.sv
// tb_divisor_nb: randomized bench for divisor_nb at WIDTH=4 and WIDTH=8,
// compared against an arithmetic reference (num / den, num % den).
module tb_divisor_nb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up4 = 1'b0, down4 = 1'b0, ok4 = 1'b0;
    logic       up8 = 1'b0, down8 = 1'b0, ok8 = 1'b0;
    logic [3:0] leds4;
    logic [7:0] leds8;
    logic [2:0] phase4, phase8;
    logic       busy4, done4, err4, busy8, done8, err8;

    int vectors = 0;
    int miscompares = 0;
    int m_num[2];
    int m_den[2];

    always #5 clk = ~clk;

    divisor_nb #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .up(up4), .down(down4), .ok(ok4),
        .leds(leds4), .phase(phase4), .busy(busy4), .done(done4), .err(err4)
    );

    divisor_nb #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .up(up8), .down(down8), .ok(ok8),
        .leds(leds8), .phase(phase8), .busy(busy8), .done(done8), .err(err8)
    );

    function automatic logic [7:0] g_leds(input bit w8);
        return w8 ? leds8 : {4'b0000, leds4};
    endfunction
    function automatic logic [2:0] g_phase(input bit w8);
        return w8 ? phase8 : phase4;
    endfunction
    function automatic logic g_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction
    function automatic logic g_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction
    function automatic logic g_err(input bit w8);
        return w8 ? err8 : err4;
    endfunction

    // One clock of stimulus to the selected instance; returns 1 time unit
    // after the rising edge, with the inputs released.
    task automatic cyc(input bit w8, input logic u, input logic d, input logic o);
        @(negedge clk);
        up4 = w8 ? 1'b0 : u;  down4 = w8 ? 1'b0 : d;  ok4 = w8 ? 1'b0 : o;
        up8 = w8 ? u : 1'b0;  down8 = w8 ? d : 1'b0;  ok8 = w8 ? o : 1'b0;
        @(posedge clk);
        #1;
        up4 = 1'b0; down4 = 1'b0; ok4 = 1'b0;
        up8 = 1'b0; down8 = 1'b0; ok8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            bit w8 = (w == 1);
            vectors++; if (g_leds(w8) !== 8'd0) begin miscompares++; $display("FAIL reset_leds w8=%0d: got %0d want 0", w8, g_leds(w8)); end
            vectors++; if (g_phase(w8) !== 3'd0) begin miscompares++; $display("FAIL reset_phase w8=%0d: got %0d want 0", w8, g_phase(w8)); end
            vectors++; if ({g_busy(w8), g_done(w8), g_err(w8)} !== 3'b000) begin miscompares++; $display("FAIL reset_flags w8=%0d: got %b want 000", w8, {g_busy(w8), g_done(w8), g_err(w8)}); end
            m_num[w] = 0;
            m_den[w] = 0;
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_wrap();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++; if (leds4 !== 4'd15) begin miscompares++; $display("FAIL wrap_down: got %0d want 15", leds4); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++; if (leds4 !== 4'd0) begin miscompares++; $display("FAIL wrap_up: got %0d want 0", leds4); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        vectors++; if (leds4 !== 4'd0) begin miscompares++; $display("FAIL up_down_same: got %0d want 0", leds4); end
        vectors++; if (phase4 !== 3'd0) begin miscompares++; $display("FAIL wrap_phase: got %0d want 0", phase4); end
        m_num[0] = 0;
    endtask

    // Random edits followed by the shortest walk to the target value.
    task automatic enter_value(input bit w8, input int target, input bit is_den);
        int w    = w8 ? 1 : 0;
        int mask = w8 ? 255 : 15;
        int cur  = is_den ? m_den[w] : m_num[w];
        int n    = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            logic u = 1'($urandom_range(0, 1));
            logic d = 1'($urandom_range(0, 1));
            cyc(w8, u, d, 1'b0);
            if (u && !d) cur = (cur + 1) & mask;
            else if (d && !u) cur = (cur + mask) & mask;
            vectors++; if (g_leds(w8) !== 8'(cur)) begin miscompares++; $display("FAIL edit w8=%0d: got %0d want %0d", w8, g_leds(w8), cur); end
        end
        while (cur != target) begin
            if (((target - cur) & mask) <= (mask + 1) / 2) begin
                cyc(w8, 1'b1, 1'b0, 1'b0);
                cur = (cur + 1) & mask;
            end else begin
                cyc(w8, 1'b0, 1'b1, 1'b0);
                cur = (cur + mask) & mask;
            end
        end
        vectors++; if (g_leds(w8) !== 8'(target)) begin miscompares++; $display("FAIL enter w8=%0d: got %0d want %0d", w8, g_leds(w8), target); end
        if (is_den) m_den[w] = cur; else m_num[w] = cur;
    endtask

    task automatic test_divide(input bit w8, input int n, input int d, input bit noise);
        int w    = w8 ? 1 : 0;
        int wd   = w8 ? 8 : 4;
        int mask = w8 ? 255 : 15;
        int dd   = d;
        int eq, er;
        logic eerr;
        vectors++; if (g_phase(w8) !== 3'd0) begin miscompares++; $display("FAIL start_phase w8=%0d: got %0d want 0", w8, g_phase(w8)); end
        enter_value(w8, n, 1'b0);
        cyc(w8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        vectors++; if (g_phase(w8) !== 3'd1 || g_leds(w8) !== 8'(m_den[w])) begin miscompares++; $display("FAIL ok_num w8=%0d: got phase %0d leds %0d want 1 %0d", w8, g_phase(w8), g_leds(w8), m_den[w]); end
        enter_value(w8, dd, 1'b1);
`ifdef DIVISOR_ZERO_GUARD_EN
        if (dd == 0) begin
            cyc(w8, 1'b0, 1'b0, 1'b1);
            vectors++; if (g_phase(w8) !== 3'd1 || g_err(w8) !== 1'b1 || g_busy(w8) !== 1'b0) begin miscompares++; $display("FAIL guard_block w8=%0d: got phase %0d err %b busy %b want 1 1 0", w8, g_phase(w8), g_err(w8), g_busy(w8)); end
            cyc(w8, 1'b1, 1'b0, 1'b0);
            dd = 1;
            m_den[w] = 1;
        end
`endif
        if (dd == 0) begin eq = mask; er = n; eerr = 1'b1; end
        else begin eq = n / dd; er = n % dd; eerr = 1'b0; end
        cyc(w8, noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
        vectors++; if (g_phase(w8) !== 3'd2 || g_busy(w8) !== 1'b1 || g_leds(w8) !== 8'd0) begin miscompares++; $display("FAIL div_enter w8=%0d: got phase %0d busy %b leds %0d want 2 1 0", w8, g_phase(w8), g_busy(w8), g_leds(w8)); end
        vectors++; if (g_err(w8) !== eerr) begin miscompares++; $display("FAIL div_err w8=%0d: got %b want %b", w8, g_err(w8), eerr); end
        for (int k = 1; k <= wd; k++) begin
            cyc(w8, noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (k < wd) begin
                vectors++; if (g_busy(w8) !== 1'b1 || g_done(w8) !== 1'b0) begin miscompares++; $display("FAIL div_busy w8=%0d k=%0d: got busy %b done %b want 1 0", w8, k, g_busy(w8), g_done(w8)); end
            end else begin
                vectors++; if (g_done(w8) !== 1'b1 || g_busy(w8) !== 1'b0 || g_phase(w8) !== 3'd5) begin miscompares++; $display("FAIL div_done w8=%0d: got done %b busy %b phase %0d want 1 0 5", w8, g_done(w8), g_busy(w8), g_phase(w8)); end
                vectors++; if (g_leds(w8) !== 8'(eq)) begin miscompares++; $display("FAIL quo w8=%0d %0d/%0d: got %0d want %0d", w8, n, dd, g_leds(w8), eq); end
                vectors++; if (g_err(w8) !== eerr) begin miscompares++; $display("FAIL quo_err w8=%0d: got %b want %b", w8, g_err(w8), eerr); end
            end
        end
        cyc(w8, 1'b0, 1'b0, 1'b0);
        vectors++; if (g_done(w8) !== 1'b0 || g_phase(w8) !== 3'd5 || g_leds(w8) !== 8'(eq)) begin miscompares++; $display("FAIL done_pulse w8=%0d: got done %b phase %0d leds %0d want 0 5 %0d", w8, g_done(w8), g_phase(w8), g_leds(w8), eq); end
        cyc(w8, 1'b0, 1'b0, 1'b1);
        vectors++; if (g_phase(w8) !== 3'd6 || g_leds(w8) !== 8'(er)) begin miscompares++; $display("FAIL rem w8=%0d %0d/%0d: got phase %0d leds %0d want 6 %0d", w8, n, dd, g_phase(w8), g_leds(w8), er); end
        cyc(w8, 1'b0, 1'b0, 1'b1);
        vectors++; if (g_phase(w8) !== 3'd0 || g_leds(w8) !== 8'(n) || g_err(w8) !== 1'b0) begin miscompares++; $display("FAIL back_to_num w8=%0d: got phase %0d leds %0d err %b want 0 %0d 0", w8, g_phase(w8), g_leds(w8), g_err(w8), n); end
    endtask

    task automatic test_reset_mid(input bit w8);
        enter_value(w8, 11, 1'b0);
        cyc(w8, 1'b0, 1'b0, 1'b1);
        enter_value(w8, 2, 1'b1);
        cyc(w8, 1'b0, 1'b0, 1'b1);
        cyc(w8, 1'b0, 1'b0, 1'b0);
        cyc(w8, 1'b0, 1'b0, 1'b0);
        vectors++; if (g_busy(w8) !== 1'b1) begin miscompares++; $display("FAIL mid_busy w8=%0d: got %b want 1", w8, g_busy(w8)); end
        #2;
        rst = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            bit s = (w == 1);
            vectors++; if (g_leds(s) !== 8'd0 || g_phase(s) !== 3'd0) begin miscompares++; $display("FAIL mid_reset_out w8=%0d: got leds %0d phase %0d want 0 0", s, g_leds(s), g_phase(s)); end
            vectors++; if ({g_busy(s), g_done(s), g_err(s)} !== 3'b000) begin miscompares++; $display("FAIL mid_reset_flags w8=%0d: got %b want 000", s, {g_busy(s), g_done(s), g_err(s)}); end
            m_num[w] = 0;
            m_den[w] = 0;
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_divide(1'b0, 13, 3, 1'b0);
        test_divide(1'b0, 15, 1, 1'b1);
        test_divide(1'b0, 0, 7, 1'b1);
        test_divide(1'b0, 9, 0, 1'b0);
        test_reset_mid(1'b0);
        test_divide(1'b0, 6, 4, 1'b1);
        test_divide(1'b1, 200, 7, 1'b1);
        test_divide(1'b1, 255, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            test_divide(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
            test_divide(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
